// File: rtl/microwave_pkg.sv
// Shared constants and state encoding for the microwave cooking controller.
package microwave_pkg;

    localparam int unsigned TICKS_PER_SEC_DEF = 100;
    localparam int unsigned BCD_W             = 4;
    localparam int unsigned NUM_KEYS          = 10;
    localparam int unsigned STATE_W           = 2;

    localparam logic [STATE_W-1:0] ST_IDLE_ENC    = 2'd0;
    localparam logic [STATE_W-1:0] ST_PROGRAM_ENC = 2'd1;
    localparam logic [STATE_W-1:0] ST_COOK_ENC    = 2'd2;
    localparam logic [STATE_W-1:0] ST_PAUSE_ENC   = 2'd3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = ST_IDLE_ENC,
        ST_PROGRAM = ST_PROGRAM_ENC,
        ST_COOK    = ST_COOK_ENC,
        ST_PAUSE   = ST_PAUSE_ENC
    } cook_state_e;

endpackage

// File: rtl/key_encoder.sv
// Combinational 10-key pad encoder: one-hot / any-pressed flags and BCD index.
module key_encoder
    import microwave_pkg::*;
(
    input  logic [NUM_KEYS-1:0] keys,
    output logic                onehot_c,
    output logic                any_c,
    output logic [BCD_W-1:0]    code_c
);

    always_comb begin
        any_c    = |keys;
        // a single set bit clears to zero when the lowest set bit is removed
        onehot_c = any_c && ((keys & (keys - NUM_KEYS'(1))) == '0);
        code_c   = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (keys[i]) begin
                code_c = BCD_W'(i);
            end
        end
    end

endmodule

// File: rtl/cook_controller.sv
// Microwave sequencing FSM: digit entry, start/stop/clear handling, cook prescaler
// producing one-second decrement strobes, and magnetron enable.
module cook_controller
    import microwave_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = TICKS_PER_SEC_DEF
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 startn,
    input  logic                 stopn,
    input  logic                 clearn,
    input  logic                 door_closed,
    input  logic [NUM_KEYS-1:0]  keys,
    input  logic                 timer_zero,
    output logic                 digit_valid,
    output logic [BCD_W-1:0]     digit_code,
    output logic                 timer_clear,
    output logic                 timer_dec,
    output logic                 mag_on,
    output logic [STATE_W-1:0]   state
);

    localparam int unsigned PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

    cook_state_e          state_q, state_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic                 keys_idle_q, keys_idle_d;
    logic                 digit_valid_q, digit_valid_d;
    logic [BCD_W-1:0]     digit_code_q, digit_code_d;
    logic                 timer_clear_q, timer_clear_d;
    logic                 timer_dec_q, timer_dec_d;
    logic                 mag_on_q, mag_on_d;

    logic                 key_onehot_c;
    logic                 key_any_c;
    logic [BCD_W-1:0]     key_code_c;
    logic                 key_new_c;
    logic                 run_ok_c;

    key_encoder u_key_encoder (
        .keys     (keys),
        .onehot_c (key_onehot_c),
        .any_c    (key_any_c),
        .code_c   (key_code_c)
    );

    // next-state, prescaler and strobe decode; clear outranks everything
    always_comb begin
        key_new_c     = key_onehot_c && keys_idle_q;
        run_ok_c      = !startn && stopn && door_closed;
        state_d       = state_q;
        presc_d       = presc_q;
        keys_idle_d   = !key_any_c;
        digit_valid_d = 1'b0;
        digit_code_d  = digit_code_q;
        timer_clear_d = 1'b0;
        timer_dec_d   = 1'b0;

        if (!clearn) begin
            state_d       = ST_IDLE;
            presc_d       = '0;
            timer_clear_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (key_new_c) begin
                        state_d       = ST_PROGRAM;
                        digit_valid_d = 1'b1;
                        digit_code_d  = key_code_c;
                    end
                end
                ST_PROGRAM: begin
                    if (run_ok_c && !timer_zero) begin
                        state_d = ST_COOK;
                        presc_d = '0;
                    end else if (key_new_c) begin
                        digit_valid_d = 1'b1;
                        digit_code_d  = key_code_c;
                    end
                end
                ST_COOK: begin
                    if (!stopn || !door_closed) begin
                        state_d = ST_PAUSE;
                    end else if (timer_zero) begin
                        state_d = ST_IDLE;
                        presc_d = '0;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d     = '0;
                        timer_dec_d = 1'b1;
                    end else begin
                        presc_d = presc_q + PRESC_W'(1);
                    end
                end
                ST_PAUSE: begin
                    if (run_ok_c) begin
                        state_d = ST_COOK;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        mag_on_d = (state_d == ST_COOK);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            presc_q       <= '0;
            keys_idle_q   <= 1'b1;
            digit_valid_q <= 1'b0;
            digit_code_q  <= '0;
            timer_clear_q <= 1'b0;
            timer_dec_q   <= 1'b0;
            mag_on_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            keys_idle_q   <= keys_idle_d;
            digit_valid_q <= digit_valid_d;
            digit_code_q  <= digit_code_d;
            timer_clear_q <= timer_clear_d;
            timer_dec_q   <= timer_dec_d;
            mag_on_q      <= mag_on_d;
        end
    end

    assign digit_valid = digit_valid_q;
    assign digit_code  = digit_code_q;
    assign timer_clear = timer_clear_q;
    assign timer_dec   = timer_dec_q;
    assign mag_on      = mag_on_q;
    assign state       = state_q;

endmodule

// File: tb/tb_cook_controller.sv
// Self-checking bench for cook_controller: directed scenarios plus randomized
// panel activity, all compared every cycle against a behavioural model.
module tb_cook_controller;
    import microwave_pkg::*;

    localparam int unsigned T = 100;

    typedef struct {
        int         st;
        int         el;
        bit         prev_zero;
        bit         dv;
        logic [3:0] code;
        bit         clr;
        bit         dec;
        bit         mag;
    } model_t;

    logic       clock       = 1'b0;
    logic       resetn      = 1'b0;
    logic       startn      = 1'b1;
    logic       stopn       = 1'b1;
    logic       clearn      = 1'b1;
    logic       door_closed = 1'b1;
    logic       timer_zero  = 1'b0;
    logic [9:0] keys        = 10'b0001001000;

    logic       digit_valid;
    logic [3:0] digit_code;
    logic       timer_clear;
    logic       timer_dec;
    logic       mag_on;
    logic [1:0] state;

    int         checks = 0;
    int         passed = 0;
    int         cyc    = 0;
    int         dv_cnt = 0;
    int         dec_cnt = 0;
    logic [3:0] last_code = 4'd0;
    model_t     m;

    always #5 clock = ~clock;

    cook_controller #(.TICKS_PER_SEC(T)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .startn      (startn),
        .stopn       (stopn),
        .clearn      (clearn),
        .door_closed (door_closed),
        .keys        (keys),
        .timer_zero  (timer_zero),
        .digit_valid (digit_valid),
        .digit_code  (digit_code),
        .timer_clear (timer_clear),
        .timer_dec   (timer_dec),
        .mag_on      (mag_on),
        .state       (state)
    );

    function automatic logic [3:0] key_index(input logic [9:0] k);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (k[i]) r = 4'(i);
        end
        return r;
    endfunction

    function automatic model_t model_reset();
        model_t r;
        r.st = 0; r.el = 0; r.prev_zero = 1'b1; r.dv = 1'b0;
        r.code = 4'd0; r.clr = 1'b0; r.dec = 1'b0; r.mag = 1'b0;
        return r;
    endfunction

    // elapsed cook time counted in cycles; a decrement falls on every multiple of T
    function automatic model_t model_step(input model_t c);
        model_t n;
        bit accept;
        bit go;
        n      = c;
        accept = ($countones(keys) == 1) && c.prev_zero;
        go     = !startn && stopn && door_closed;
        n.dv = 1'b0; n.clr = 1'b0; n.dec = 1'b0;
        if (!clearn) begin
            n.st = 0; n.el = 0; n.clr = 1'b1;
        end else if (c.st == 0) begin
            if (accept) n.st = 1;
            n.dv = accept;
        end else if (c.st == 1) begin
            if (go && !timer_zero) begin
                n.st = 2; n.el = 0;
            end else begin
                n.dv = accept;
            end
        end else if (c.st == 2) begin
            if (!stopn || !door_closed) n.st = 3;
            else if (timer_zero) n.st = 0;
            else begin
                n.el  = c.el + 1;
                n.dec = (n.el % T) == 0;
            end
        end else if (go) begin
            n.st = 2;
        end
        if (n.dv) n.code = key_index(keys);
        n.prev_zero = (keys == 10'd0);
        n.mag       = (n.st == 2);
        return n;
    endfunction

    always @(posedge clock or negedge resetn) begin
        if (!resetn) m <= model_reset();
        else         m <= model_step(m);
    end

    always @(posedge clock) cyc <= cyc + 1;

    // per-cycle comparison against the model, plus pulse bookkeeping
    always @(negedge clock) begin
        checks++;
        if (state !== 2'(m.st) || digit_valid !== m.dv || timer_clear !== m.clr ||
            timer_dec !== m.dec || mag_on !== m.mag || (m.dv && digit_code !== m.code)) begin
            $display("FAIL model cyc=%0d got st=%0d dv=%b code=%0d clr=%b dec=%b mag=%b want st=%0d dv=%b code=%0d clr=%b dec=%b mag=%b",
                     cyc, state, digit_valid, digit_code, timer_clear, timer_dec, mag_on,
                     m.st, m.dv, m.code, m.clr, m.dec, m.mag);
        end else begin
            passed++;
        end
        if (digit_valid) begin
            dv_cnt++;
            last_code = digit_code;
        end
        if (timer_dec) dec_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else passed++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic press_key(input int d);
        keys = 10'd0;
        tick(2);
        keys = 10'(1 << d);
        tick(3);
        keys = 10'd0;
        tick(2);
    endtask

    task automatic start_pulse();
        startn = 1'b0;
        tick(1);
        startn = 1'b1;
    endtask

    task automatic wait_dec(input int lim, output int at);
        at = -1;
        for (int i = 0; i < lim; i++) begin
            tick(1);
            if (timer_dec) begin
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        int d0;
        int e;
        int got;
        int r;

        tick(3);
        check("reset_outputs", 32'({digit_valid, timer_clear, timer_dec, mag_on, state}), 32'd0);
        check("reset_code", 32'(digit_code), 32'd0);
        resetn = 1'b1;

        d0 = dv_cnt;
        tick(5);
        check("multikey_rejected", 32'(dv_cnt - d0), 32'd0);
        check("multikey_state_idle", 32'(state), 32'd0);

        keys = 10'd0;
        tick(2);
        d0   = dv_cnt;
        keys = 10'b0000001000;
        tick(50);
        check("held_key_one_pulse", 32'(dv_cnt - d0), 32'd1);
        check("held_key_code", 32'(last_code), 32'd3);
        check("state_program", 32'(state), 32'd1);
        keys = 10'd0;
        tick(1);

        start_pulse();
        e = cyc;
        check("mag_on_cook", 32'(mag_on), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            wait_dec(150, got);
            check("dec_spacing", 32'(got - e), 32'(100 * k));
        end
        timer_zero = 1'b1;
        tick(1);
        check("zero_mag_off", 32'(mag_on), 32'd0);
        check("zero_state_idle", 32'(state), 32'd0);
        d0 = dec_cnt;
        tick(150);
        check("no_fourth_dec", 32'(dec_cnt - d0), 32'd0);
        timer_zero = 1'b0;

        press_key(5);
        check("key5_code", 32'(last_code), 32'd5);
        start_pulse();
        e = cyc;
        tick(40);
        door_closed = 1'b0;
        tick(1);
        check("door_open_mag_off", 32'(mag_on), 32'd0);
        check("door_open_pause", 32'(state), 32'd3);
        tick(10);
        door_closed = 1'b1;
        tick(1);
        start_pulse();
        r = cyc;
        check("resume_cook", 32'(state), 32'd2);
        wait_dec(100, got);
        check("resume_dec_60", 32'(got - r), 32'd60);

        stopn = 1'b0;
        tick(1);
        stopn = 1'b1;
        check("stop_pause", 32'(state), 32'd3);
        clearn = 1'b0;
        tick(1);
        clearn = 1'b1;
        check("clear_from_pause", 32'({timer_clear, state}), 32'b100);

        press_key(7);
        check("key7_program", 32'({last_code, state}), 32'b0111_01);
        startn = 1'b0;
        stopn  = 1'b0;
        tick(3);
        check("start_with_stop", 32'({mag_on, state}), 32'b0_01);
        stopn      = 1'b1;
        timer_zero = 1'b1;
        tick(2);
        check("start_timer_zero", 32'(state), 32'd1);
        timer_zero  = 1'b0;
        door_closed = 1'b0;
        tick(2);
        check("start_door_open", 32'(state), 32'd1);
        startn      = 1'b1;
        door_closed = 1'b1;
        tick(1);
        start_pulse();
        check("cook_again", 32'(state), 32'd2);
        tick(5);
        clearn = 1'b0;
        tick(1);
        check("clear_in_cook", 32'({timer_clear, mag_on, state}), 32'b1_0_00);
        tick(2);
        check("clear_held_repeats", 32'(timer_clear), 32'd1);
        clearn = 1'b1;
        tick(1);

        press_key(2);
        start_pulse();
        tick(10);
        @(posedge clock);
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset_mag", 32'(mag_on), 32'd0);
        check("async_reset_state", 32'(state), 32'd0);
        tick(2);
        resetn = 1'b1;
        tick(1);
        check("post_reset_idle", 32'(state), 32'd0);

        for (int i = 0; i < 20000; i++) begin
            clearn     = ($urandom_range(0, 499) != 0);
            stopn      = ($urandom_range(0, 299) != 0);
            startn     = ($urandom_range(0, 19) != 0);
            timer_zero = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 399) == 0) door_closed = ~door_closed;
            if ($urandom_range(0, 5) == 0) begin
                r = int'($urandom_range(0, 9));
                if (r < 4)      keys = 10'd0;
                else if (r < 8) keys = 10'(1 << $urandom_range(0, 9));
                else            keys = 10'($urandom);
            end
            tick(1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
